// File: rtl/pu_input_streamer_pkg.sv
// Shared definitions for the PU input streamer.
// - state_e       : FSM encoding, also exported on the debug port
// - clog2         : ceiling log2 for parameter arithmetic
// - ceil_a_by_b   : integer ceiling division
// - lane_width    : lane counter width, never narrower than one bit
package pu_input_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // With a single lane the counter is unused but still needs a legal width.
  function automatic int lane_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_stream_fifo.sv
// Synchronous FIFO for packed PU words.
// - clk, reset_n          : clock, asynchronous active-low reset
// - push, push_data       : write port; a push while full is honoured only
//                           when a pop happens in the same cycle
// - pop                   : read request; ignored while empty
// - full, empty           : occupancy flags
// - rd_data               : registered read data, updated on each pop and
//                           held otherwise
module pu_stream_fifo #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              do_push, do_pop;

  assign full    = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = rd_data_q;

  // When full, a simultaneous pop frees the slot the push lands in; the read
  // below samples the old contents at the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pu_input_streamer.sv
// Packs a scalar operand stream into NUM_PE-wide words for the convolution PU.
// Each row of cfg_width operands becomes ceil(width/NUM_PE) words, the tail
// lanes of a row's last word being zero.
// - clk, reset_n            : clock, asynchronous active-low reset
// - cfg_start/width/rows    : layer configuration, latched on cfg_start in IDLE
// - busy, done              : layer in progress / one-cycle completion pulse
// - mem_data/valid/ready    : upstream operand handshake; a beat transfers on a
//                             rising edge where mem_valid and mem_ready are both
//                             high. mem_ready never depends on mem_valid.
// - pu_rd_req/pu_rd_ready   : PU read; a pop happens on an edge where both are
//                             high, and pu_data_in carries that word from the
//                             following cycle until the next pop
// - rd_underflow            : sticky, pu_rd_req seen with pu_rd_ready low
// - dbg_state               : current FSM state
module pu_input_streamer
  import pu_input_streamer_pkg::*;
#(
  parameter int OP_WIDTH    = 16,
  parameter int NUM_PE      = 4,
  parameter int DIM_WIDTH   = 16,
  parameter int FIFO_ADDR_W = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_start,
  input  logic [DIM_WIDTH-1:0]         cfg_width,
  input  logic [DIM_WIDTH-1:0]         cfg_rows,
  output logic                         busy,
  output logic                         done,
  input  logic [OP_WIDTH-1:0]          mem_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic                         pu_rd_req,
  output logic                         pu_rd_ready,
  output logic [OP_WIDTH*NUM_PE-1:0]   pu_data_in,
  output logic                         rd_underflow,
  output state_e                       dbg_state
);

  localparam int DATA_WIDTH = OP_WIDTH * NUM_PE;
  localparam int LANE_W     = lane_width(NUM_PE);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_PE - 1);

  state_e                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   width_q, width_d;
  logic [DIM_WIDTH-1:0]   rows_q, rows_d;
  logic [DIM_WIDTH-1:0]   col_q, col_d;
  logic [DIM_WIDTH-1:0]   row_q, row_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic                   word_valid_q, word_valid_d;  // word_q complete, awaiting push
  logic                   done_q, done_d;
  logic                   underflow_q, underflow_d;

  logic                   fifo_full, fifo_empty;
  logic                   push, pop, stall, lane_adv;
  logic [OP_WIDTH-1:0]    lane_val;

  assign pop   = pu_rd_req && !fifo_empty;
  assign push  = word_valid_q && (!fifo_full || pop);
  // A completed word that cannot leave freezes the packer.
  assign stall = word_valid_q && !push;

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign pu_rd_ready  = !fifo_empty;
  assign rd_underflow = underflow_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    rows_d       = rows_q;
    col_d        = col_q;
    row_d        = row_q;
    lane_d       = lane_q;
    word_d       = word_q;
    word_valid_d = word_valid_q && !push;
    done_d       = 1'b0;
    underflow_d  = underflow_q;
    mem_ready    = 1'b0;
    lane_adv     = 1'b0;
    lane_val     = '0;

    if (pu_rd_req && fifo_empty) underflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          width_d     = cfg_width;
          rows_d      = cfg_rows;
          col_d       = '0;
          row_d       = '0;
          lane_d      = '0;
          underflow_d = 1'b0;
          state_d     = (cfg_width == '0 || cfg_rows == '0) ? ST_DRAIN : ST_PACK;
        end
      end
      ST_PACK: begin
        if (!stall) begin
          if (col_q < width_q) begin
            mem_ready = 1'b1;
            if (mem_valid) begin
              lane_adv = 1'b1;
              lane_val = mem_data;
              col_d    = col_q + DIM_WIDTH'(1);
            end
          end else begin
            // Row exhausted: pad this lane with zero without consuming a beat.
            lane_adv = 1'b1;
          end
        end
        if (lane_adv) begin
          if (lane_q == LAST_LANE) begin
            lane_d       = '0;
            word_valid_d = 1'b1;
            if (col_d >= width_q) begin
              col_d = '0;
              row_d = row_q + DIM_WIDTH'(1);
              if (row_q + DIM_WIDTH'(1) == rows_q) state_d = ST_DRAIN;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The last word may still be waiting to enter the FIFO.
        if (!word_valid_q && fifo_empty) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_PE; i++) begin
      if (lane_adv && (lane_q == LANE_W'(i))) word_d[i*OP_WIDTH +: OP_WIDTH] = lane_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      rows_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      rows_q       <= rows_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
    end
  end

  pu_stream_fifo #(
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (word_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_data   (pu_data_in)
  );

endmodule
